// File: rtl/usb_in_packetizer.sv
// usb_in_packetizer
// Drains the endpoint byte queue and frames it as a USB IN data packet:
// DATA0/DATA1 PID, up to MAX_PKT payload bytes, then CRC16 low and high bytes.
// The endpoint data toggle is kept here. Nothing is retransmitted: a packet
// that is not ACKed is simply lost and the toggle is left as it was.
//
// Ports
//   clk         sole clock (the queue read side runs on it too)
//   rst         synchronous reset, active low
//   in_req      pulse: host IN token for this endpoint
//   ack         pulse: host ACK for the last packet (flips the toggle)
//   toggle_clr  pulse: force DATA0 (wins over a simultaneous ack)
//   q_data      queue head byte, q_empty queue empty flag
//   q_r_en      pop strobe, combinational, one cycle per consumed byte
//   tx_data     registered byte to the transmitter
//   tx_valid    registered, tx_data valid
//   tx_ready    transmitter takes the byte when tx_valid && tx_ready
//   tx_last     registered, high with the CRC high byte
//   busy        high whenever a packet is in progress
module usb_in_packetizer #(
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_req,
    input  logic       ack,
    input  logic       toggle_clr,
    input  logic [7:0] q_data,
    input  logic       q_empty,
    output logic       q_r_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW:0] MAX_PKT_W = (CW + 1)'(MAX_PKT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic            tx_valid_reg, tx_valid_next;
    logic            tx_last_reg, tx_last_next;
    logic [15:0]     crc_reg, crc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            toggle_reg, toggle_next;

    logic            accept;
    logic [CW:0]     count_inc;
    logic [15:0]     crc_n;

    // Reflected CRC16 (0xA001), one stage per payload bit, LSB first.
    // The byte being folded in is the one currently held in tx_data.
    logic [8:0][15:0] crc_stage;
    assign crc_stage[0] = crc_reg;
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc
        assign crc_stage[gi+1] = (crc_stage[gi][0] ^ tx_data_reg[gi])
                               ? ((crc_stage[gi] >> 1) ^ 16'hA001)
                               : (crc_stage[gi] >> 1);
    end
    assign crc_n = crc_stage[8];

    assign accept    = tx_valid_reg && tx_ready;
    assign count_inc = {1'b0, count_reg} + 1'b1;

    always_comb begin
        state_next    = state_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        tx_last_next  = tx_last_reg;
        crc_next      = crc_reg;
        count_next    = count_reg;
        q_r_en        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tx_valid_next = 1'b0;
                if (in_req) begin
                    // PID is fixed here; toggle changes during the packet
                    // do not reach it.
                    tx_data_next  = toggle_reg ? 8'h4B : 8'hC3;
                    tx_valid_next = 1'b1;
                    crc_next      = 16'hFFFF;
                    count_next    = '0;
                    state_next    = S_PID;
                end
            end
            S_PID: begin
                if (accept) begin
                    if (!q_empty) begin
                        tx_data_next = q_data;
                        q_r_en       = 1'b1;
                        state_next   = S_DATA;
                    end else begin
                        // Zero-length packet: CRC of nothing is ~0xFFFF.
                        tx_data_next = ~crc_reg[7:0];
                        state_next   = S_CRC_LO;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    crc_next   = crc_n;
                    count_next = count_inc[CW-1:0];
                    if (count_inc < MAX_PKT_W && !q_empty) begin
                        tx_data_next = q_data;
                        q_r_en       = 1'b1;
                    end else begin
                        // Full packet or queue ran dry: close with the CRC
                        // rather than stalling tx_valid.
                        tx_data_next = ~crc_n[7:0];
                        state_next   = S_CRC_LO;
                    end
                end
            end
            S_CRC_LO: begin
                if (accept) begin
                    tx_data_next = ~crc_reg[15:8];
                    tx_last_next = 1'b1;
                    state_next   = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (accept) begin
                    tx_valid_next = 1'b0;
                    tx_last_next  = 1'b0;
                    state_next    = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // No pops while reset is held, even if the state is still mid-packet.
        if (!rst) begin
            q_r_en = 1'b0;
        end
    end

    always_comb begin
        toggle_next = toggle_reg;
        if (toggle_clr) begin
            toggle_next = 1'b0;
        end else if (ack) begin
            toggle_next = ~toggle_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            tx_last_reg  <= 1'b0;
            crc_reg      <= 16'hFFFF;
            count_reg    <= '0;
            toggle_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            tx_last_reg  <= tx_last_next;
            crc_reg      <= crc_next;
            count_reg    <= count_next;
            toggle_reg   <= toggle_next;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign tx_last  = tx_last_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Directed bench for usb_in_packetizer: zero-length packet, CRC check value,
// toggle sequencing, MAX_PKT split, random backpressure and mid-packet reset.
module tb_usb_in_packetizer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_req = 1'b0;
    logic       ack = 1'b0;
    logic       toggle_clr = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] q_data;
    logic       q_empty;
    logic       q_r_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       busy;

    usb_in_packetizer #(.MAX_PKT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .ack        (ack),
        .toggle_clr (toggle_clr),
        .q_data     (q_data),
        .q_empty    (q_empty),
        .q_r_en     (q_r_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Endpoint queue: written by the stimulus, popped by the DUT.
    logic [7:0] qmem [0:255];
    int         q_wr = 0;
    int         q_rd = 0;
    bit         flush_req = 1'b0;
    assign q_data  = qmem[q_rd[7:0]];
    assign q_empty = (q_rd == q_wr);

    // Monitor
    logic [7:0] cap_data [$];
    bit         cap_last [$];
    int         pop_cnt = 0;
    int         valid_cnt = 0;
    int         empty_pop = 0;
    int         stall_pop = 0;
    int         stall_viol = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(posedge clk) begin
        if (flush_req) q_rd <= q_wr;
        else if (q_r_en) q_rd <= q_rd + 1;
        if (q_r_en) pop_cnt <= pop_cnt + 1;
        if (q_r_en && q_empty) empty_pop <= empty_pop + 1;
        if (q_r_en && !tx_ready) stall_pop <= stall_pop + 1;
        if (tx_valid) valid_cnt <= valid_cnt + 1;
        if (tx_valid && tx_ready) begin
            cap_data.push_back(tx_data);
            cap_last.push_back(tx_last);
        end
        if (prev_stall && rst && (tx_data != prev_data || tx_last != prev_last || !tx_valid))
            stall_viol <= stall_viol + 1;
        prev_stall <= tx_valid && !tx_ready && rst;
        prev_data  <= tx_data;
        prev_last  <= tx_last;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        qmem[q_wr[7:0]] = b;
        q_wr++;
    endtask

    // Reference CRC: non-reflected 0x8005 register fed LSB-first, then
    // bit-reversed and inverted; result low byte goes out first.
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return ~r;
    endfunction

    int base;
    int pop0;
    int vc0;

    task automatic send(input string tag, input bit rnd, input logic [7:0] exp_pid);
        base = cap_data.size();
        pop0 = pop_cnt;
        vc0  = valid_cnt;
        @(negedge clk);
        in_req = 1'b1;
        @(negedge clk);
        in_req = 1'b0;
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
        check_eq({tag, "_valid_start"}, 32'(tx_valid), 32'd1);
        check_eq({tag, "_pid"}, 32'(tx_data), 32'(exp_pid));
        for (int c = 0; c < 4000 && busy; c++) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        tx_ready = 1'b1;
        check_eq({tag, "_done"}, 32'(busy), 32'd0);
        $display("packet %s: %0d bytes sent, %0d pops", tag,
                 cap_data.size() - base, pop_cnt - pop0);
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] exp[$]);
        int n;
        int lc;
        n  = cap_data.size() - base;
        lc = 0;
        check_eq({tag, "_len"}, 32'(n), 32'(exp.size()));
        for (int i = 0; i < n && i < exp.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(cap_data[base+i]), 32'(exp[i]));
        for (int i = 0; i < n; i++)
            if (cap_last[base+i]) lc++;
        check_eq({tag, "_last_count"}, 32'(lc), 32'd1);
        if (n > 0) check_eq({tag, "_last_final"}, 32'(cap_last[base+n-1]), 32'd1);
    endtask

    task automatic pulse(input bit do_ack, input bit do_clr);
        @(negedge clk);
        ack = do_ack;
        toggle_clr = do_clr;
        @(negedge clk);
        ack = 1'b0;
        toggle_clr = 1'b0;
    endtask

    logic [7:0] exp [$];
    logic [7:0] pl [$];
    logic [15:0] crc;
    int pr;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_tx_last", 32'(tx_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_q_r_en", 32'(q_r_en), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Zero-length packet
        send("zlp", 1'b0, 8'hC3);
        exp = '{8'hC3, 8'h00, 8'h00};
        check_pkt("zlp", exp);
        check_eq("zlp_pops", 32'(pop_cnt - pop0), 32'd0);

        // CRC check value over "123456789"
        for (int i = 0; i < 9; i++) push(8'(8'h31 + i));
        send("crc9", 1'b0, 8'hC3);
        exp = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        check_pkt("crc9", exp);
        check_eq("crc9_pops", 32'(pop_cnt - pop0), 32'd9);
        check_eq("crc9_valid_cycles", 32'(valid_cnt - vc0), 32'd12);

        // Toggle sequencing
        pulse(1'b1, 1'b0);
        send("tog1", 1'b0, 8'h4B);
        exp = '{8'h4B, 8'h00, 8'h00};
        check_pkt("tog1", exp);
        pulse(1'b1, 1'b0);
        send("tog0", 1'b0, 8'hC3);
        pulse(1'b1, 1'b1);
        send("togclr", 1'b0, 8'hC3);

        // MAX_PKT split: 70 queued -> 64 then 6
        pl.delete();
        for (int i = 0; i < 70; i++) begin
            push(8'(i * 5 + 1));
            if (i < 64) pl.push_back(8'(i * 5 + 1));
        end
        send("max", 1'b0, 8'hC3);
        crc = ref_crc(pl);
        exp = '{8'hC3};
        foreach (pl[k]) exp.push_back(pl[k]);
        exp.push_back(crc[7:0]);
        exp.push_back(crc[15:8]);
        check_pkt("max", exp);
        check_eq("max_pops", 32'(pop_cnt - pop0), 32'd64);
        check_eq("max_queue_left", 32'(q_wr - q_rd), 32'd6);

        pl.delete();
        for (int i = 64; i < 70; i++) pl.push_back(8'(i * 5 + 1));
        send("max2", 1'b0, 8'hC3);
        crc = ref_crc(pl);
        exp = '{8'hC3};
        foreach (pl[k]) exp.push_back(pl[k]);
        exp.push_back(crc[7:0]);
        exp.push_back(crc[15:8]);
        check_pkt("max2", exp);
        check_eq("max2_pops", 32'(pop_cnt - pop0), 32'd6);

        // Random backpressure on the 9-byte case
        for (int i = 0; i < 9; i++) push(8'(8'h31 + i));
        send("bp", 1'b1, 8'hC3);
        exp = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        check_pkt("bp", exp);
        check_eq("bp_pops", 32'(pop_cnt - pop0), 32'd9);
        check_eq("bp_stall_stable", 32'(stall_viol), 32'd0);
        check_eq("bp_stall_pops", 32'(stall_pop), 32'd0);

        // Reset in the middle of DATA
        for (int i = 0; i < 20; i++) push(8'(8'hA0 + i));
        pop0 = pop_cnt;
        @(negedge clk);
        in_req = 1'b1;
        @(negedge clk);
        in_req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_pops", 32'(pop_cnt - pop0), 32'd4);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_last", 32'(tx_last), 32'd0);
        pr = pop_cnt;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_no_pop", 32'(pop_cnt - pr), 32'd0);
        rst = 1'b1;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        send("post_rst", 1'b0, 8'hC3);
        exp = '{8'hC3, 8'h00, 8'h00};
        check_pkt("post_rst", exp);

        check_eq("no_pop_when_empty", 32'(empty_pop), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
